// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit between the execute stage and a fixed-latency
//            memory. Accepts one request at a time, flags illegal or
//            misaligned requests without touching memory, drives byte-lane
//            shifted store data/masks, and returns sign/zero-extended load
//            results through a valid/ready response port.
// Ports    : clk, rst_n            - clock, async active-low reset
//            req_*                 - request from EXU (valid/ready handshake)
//            resp_*                - response to WBU (valid/ready handshake)
//            mem_raddr/rdata/ren   - memory read port (8-byte aligned)
//            mem_waddr/wdata/wmask/wen - memory write port (8-byte aligned)
// Revision : 1.0 - initial release
// ============================================================================
module lsu #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [6:0]  req_ld_type,
    input  logic [3:0]  req_st_type,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] mem_raddr,
    input  logic [63:0] mem_rdata,
    output logic        mem_ren,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic        mem_wen
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_resp   = 2'd2;
    localparam logic [3:0] c_last      = 4'(MEM_LAT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [6:0]  r_ld_type;
    logic [3:0]  r_st_type;
    logic [3:0]  r_cnt;
    logic [63:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_accept;
    logic        w_legal;
    logic        w_half;
    logic        w_word;
    logic        w_dbl;
    logic        w_misaligned;
    logic        w_req_err;
    logic        w_in_access;
    logic        w_last;
    logic        w_is_load;
    logic        w_is_store;
    logic [5:0]  w_byte_sh;
    logic [63:0] w_shifted;
    logic [63:0] w_load_data;
    logic [7:0]  w_size_mask;
    logic        w_wen;

    // ------------------------------------------------------------------
    // Request classification, evaluated on the raw request in IDLE.
    // Exactly one of the two type vectors may be non-zero, and that one
    // must be one-hot.
    // ------------------------------------------------------------------
    assign req_ready    = (r_state == c_st_idle);
    assign w_accept     = req_valid && req_ready;
    assign w_legal      = ($onehot(req_ld_type) && (req_st_type == 4'd0)) ||
                          ($onehot(req_st_type) && (req_ld_type == 7'd0));
    assign w_half       = req_ld_type[1] | req_ld_type[5] | req_st_type[1];
    assign w_word       = req_ld_type[2] | req_ld_type[6] | req_st_type[2];
    assign w_dbl        = req_ld_type[3] | req_st_type[3];
    assign w_misaligned = (w_half & req_addr[0]) |
                          (w_word & (|req_addr[1:0])) |
                          (w_dbl  & (|req_addr[2:0]));
    assign w_req_err    = !w_legal || w_misaligned;

    assign w_in_access  = (r_state == c_st_access);
    assign w_last       = (r_cnt == c_last);
    assign w_is_load    = |r_ld_type;
    assign w_is_store   = |r_st_type;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:   if (w_accept)   w_state_next = w_req_err ? c_st_resp : c_st_access;
            c_st_access: if (w_last)     w_state_next = c_st_resp;
            c_st_resp:   if (resp_ready) w_state_next = c_st_idle;
            default:     w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction: bring the addressed byte lane down to bit 0, then
    // keep the access width and extend according to the load type.
    // ------------------------------------------------------------------
    assign w_byte_sh = {r_addr[2:0], 3'b000};
    assign w_shifted = mem_rdata >> w_byte_sh;

    always_comb begin
        w_load_data = w_shifted;
        if (r_ld_type[0])      w_load_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
        else if (r_ld_type[1]) w_load_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
        else if (r_ld_type[2]) w_load_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
        else if (r_ld_type[4]) w_load_data = {56'd0, w_shifted[7:0]};
        else if (r_ld_type[5]) w_load_data = {48'd0, w_shifted[15:0]};
        else if (r_ld_type[6]) w_load_data = {32'd0, w_shifted[31:0]};
    end

    always_comb begin
        w_size_mask = 8'hFF;
        if (r_st_type[0])      w_size_mask = 8'h01;
        else if (r_st_type[1]) w_size_mask = 8'h03;
        else if (r_st_type[2]) w_size_mask = 8'h0F;
    end

    // ------------------------------------------------------------------
    // Datapath registers. The cycle counter is held at zero outside
    // ACCESS so it always starts from zero, and it saturates rather than
    // wrapping.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_ld_type    <= '0;
            r_st_type    <= '0;
            r_cnt        <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_ld_type  <= req_ld_type;
                r_st_type  <= req_st_type;
                r_resp_err <= w_req_err;
                if (w_req_err) begin
                    r_resp_rdata <= '0;
                end
            end
            if (w_in_access) begin
                if (r_cnt != 4'hF) begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end else begin
                r_cnt <= 4'd0;
            end
            // Memory data is sampled on the final ACCESS cycle and the
            // extended result is held unchanged for the whole response.
            if (w_in_access && w_last) begin
                r_resp_rdata <= w_is_load ? w_load_data : 64'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_wen      = w_in_access && w_is_store && (r_cnt == 4'd0);

    assign mem_ren    = w_in_access && w_is_load;
    assign mem_raddr  = mem_ren ? {r_addr[63:3], 3'b000} : 64'd0;
    assign mem_wen    = w_wen;
    assign mem_waddr  = (w_in_access && w_is_store) ? {r_addr[63:3], 3'b000} : 64'd0;
    assign mem_wdata  = (w_in_access && w_is_store) ? (r_wdata << w_byte_sh) : 64'd0;
    assign mem_wmask  = w_wen ? (w_size_mask << r_addr[2:0]) : 8'h00;

    assign resp_valid = (r_state == c_st_resp);
    assign resp_err   = resp_valid && r_resp_err;
    assign resp_rdata = r_resp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Self-checking bench for lsu. One instance at MEM_LAT=1 carries
//            the functional scenarios; a second at MEM_LAT=4 covers longer
//            accesses and reset in the middle of an access.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

    localparam int c_lat  = 1;
    localparam int c_lat4 = 4;

    localparam logic [6:0] c_lb  = 7'b0000001;
    localparam logic [6:0] c_lh  = 7'b0000010;
    localparam logic [6:0] c_lw  = 7'b0000100;
    localparam logic [6:0] c_ld  = 7'b0001000;
    localparam logic [6:0] c_lbu = 7'b0010000;
    localparam logic [6:0] c_lhu = 7'b0100000;
    localparam logic [6:0] c_lwu = 7'b1000000;
    localparam logic [3:0] c_sb  = 4'b0001;
    localparam logic [3:0] c_sh  = 4'b0010;
    localparam logic [3:0] c_sw  = 4'b0100;
    localparam logic [3:0] c_sd  = 4'b1000;
    localparam logic [63:0] c_pat = 64'hF0E1_D2C3_B4A5_9687;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n, rst_n4;
    logic        req_valid, req_valid4;
    logic [63:0] req_addr, req_wdata, mem_rdata;
    logic [6:0]  req_ld_type;
    logic [3:0]  req_st_type;
    logic        resp_ready;

    logic        req_ready, resp_valid, resp_err, mem_ren, mem_wen;
    logic [63:0] resp_rdata, mem_raddr, mem_waddr, mem_wdata;
    logic [7:0]  mem_wmask;

    logic        req_ready4, resp_valid4, resp_err4, mem_ren4, mem_wen4;
    logic [63:0] resp_rdata4, mem_raddr4, mem_waddr4, mem_wdata4;
    logic [7:0]  mem_wmask4;

    int checks = 0;
    int errors = 0;

    resp_t sb_q[$];

    // Observations collected by run_txn for the scenario tasks to judge
    int          obs_lat, obs_ren, obs_wen;
    logic        obs_ready_before, obs_ready_in_resp, obs_hold_ok;
    logic        obs_ready_after, obs_valid_after;
    logic [63:0] cap_raddr, cap_waddr, cap_wdata;
    logic [7:0]  cap_wmask;

    always #5 clk = ~clk;

    lsu #(.MEM_LAT(c_lat)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ld_type(req_ld_type), .req_st_type(req_st_type),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_ren(mem_ren),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_wen(mem_wen)
    );

    lsu #(.MEM_LAT(c_lat4)) dut4 (
        .clk(clk), .rst_n(rst_n4),
        .req_valid(req_valid4), .req_ready(req_ready4),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ld_type(req_ld_type), .req_st_type(req_st_type),
        .resp_valid(resp_valid4), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata4), .resp_err(resp_err4),
        .mem_raddr(mem_raddr4), .mem_rdata(mem_rdata), .mem_ren(mem_ren4),
        .mem_waddr(mem_waddr4), .mem_wdata(mem_wdata4),
        .mem_wmask(mem_wmask4), .mem_wen(mem_wen4)
    );

    // Drive one request into dut, push its expected response, observe the
    // memory side while waiting, and compare the response at the handshake.
    task automatic run_txn(input logic [6:0] ld, input logic [3:0] st,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] mdata, input logic [63:0] exp_rdata,
                           input logic exp_err, input int hold, input string name);
        resp_t       exp_e, got;
        logic [63:0] rd0;
        int          n;
        exp_e.rdata = exp_rdata;
        exp_e.err   = exp_err;
        sb_q.push_back(exp_e);
        obs_ren = 0; obs_wen = 0; obs_hold_ok = 1'b1;
        cap_raddr = '0; cap_waddr = '0; cap_wdata = '0; cap_wmask = '0;
        obs_ready_before = req_ready;
        req_ld_type = ld; req_st_type = st; req_addr = addr; req_wdata = wdata;
        mem_rdata = mdata; resp_ready = (hold == 0); req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (resp_valid !== 1'b1 && n < 40) begin
            if (mem_ren === 1'b1) begin obs_ren++; cap_raddr = mem_raddr; end
            if (mem_wen === 1'b1) begin
                obs_wen++; cap_waddr = mem_waddr; cap_wmask = mem_wmask; cap_wdata = mem_wdata;
            end
            @(posedge clk); #1; n++;
        end
        obs_lat = n;
        if (mem_ren === 1'b1) obs_ren++;
        if (mem_wen === 1'b1) obs_wen++;
        if (resp_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s timeout: resp_valid not seen within %0d cycles", name, n);
            exp_e = sb_q.pop_front();
            resp_ready = 1'b1;
            return;
        end
        obs_ready_in_resp = req_ready;
        rd0 = resp_rdata;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_rdata !== rd0 || req_ready !== 1'b0) obs_hold_ok = 1'b0;
        end
        resp_ready = 1'b1;
        exp_e = sb_q.pop_front();
        got.rdata = resp_rdata;
        got.err   = resp_err;
        checks++;
        if (got !== exp_e) begin
            errors++;
            $display("FAIL %s response: got rdata=%h err=%b, expected rdata=%h err=%b",
                     name, got.rdata, got.err, exp_e.rdata, exp_e.err);
        end
        @(posedge clk); #1;
        obs_ready_after = req_ready;
        obs_valid_after = resp_valid;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_resp: ready=%b valid=%b err=%b rdata=%h, expected 1 0 0 0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        checks++;
        if (mem_ren !== 1'b0 || mem_wen !== 1'b0 || mem_wmask !== 8'h00 ||
            mem_raddr !== 64'd0 || mem_waddr !== 64'd0 || mem_wdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_mem: ren=%b wen=%b wmask=%h raddr=%h waddr=%h wdata=%h, expected all 0",
                     mem_ren, mem_wen, mem_wmask, mem_raddr, mem_waddr, mem_wdata);
        end
        rst_n = 1'b1;
        rst_n4 = 1'b1;
    endtask

    task automatic test_lb_sign();
        run_txn(c_lb, 4'd0, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000,
                64'hFFFF_FFFF_FFFF_FF80, 1'b0, 0, "lb_sign");
        checks++;
        if (obs_ready_before !== 1'b1) begin
            errors++; $display("FAIL lb_first_accept: req_ready=%b, expected 1", obs_ready_before);
        end
        checks++;
        if (obs_lat !== 2) begin
            errors++; $display("FAIL lb_latency: resp_valid at cycle %0d, expected 2", obs_lat);
        end
        checks++;
        if (obs_ren !== c_lat) begin
            errors++; $display("FAIL lb_ren_cycles: got %0d, expected %0d", obs_ren, c_lat);
        end
    endtask

    task automatic test_lwu();
        run_txn(c_lwu, 4'd0, 64'h8000_0004, 64'd0, 64'h89AB_CDEF_0000_0000,
                64'h0000_0000_89AB_CDEF, 1'b0, 0, "lwu");
        checks++;
        if (cap_raddr !== 64'h8000_0000) begin
            errors++; $display("FAIL lwu_raddr: got %h, expected 0000000080000000", cap_raddr);
        end
    endtask

    task automatic test_loads();
        logic [6:0]  ld [7];
        logic [63:0] ad [7];
        logic [63:0] md [7];
        logic [63:0] ex [7];
        ld[0] = c_ld;  ad[0] = 64'h8000_0008; md[0] = c_pat;                ex[0] = 64'hF0E1_D2C3_B4A5_9687;
        ld[1] = c_lh;  ad[1] = 64'h8000_0006; md[1] = c_pat;                ex[1] = 64'hFFFF_FFFF_FFFF_F0E1;
        ld[2] = c_lhu; ad[2] = 64'h8000_0002; md[2] = c_pat;                ex[2] = 64'h0000_0000_0000_B4A5;
        ld[3] = c_lw;  ad[3] = 64'h8000_0010; md[3] = c_pat;                ex[3] = 64'hFFFF_FFFF_B4A5_9687;
        ld[4] = c_lbu; ad[4] = 64'h8000_0007; md[4] = c_pat;                ex[4] = 64'h0000_0000_0000_00F0;
        ld[5] = c_lb;  ad[5] = 64'h8000_0001; md[5] = 64'h0000_0000_0000_7F00; ex[5] = 64'h0000_0000_0000_007F;
        ld[6] = c_lw;  ad[6] = 64'h8000_001C; md[6] = 64'h1234_5678_0000_0000; ex[6] = 64'h0000_0000_1234_5678;
        for (int i = 0; i < 7; i++) begin
            run_txn(ld[i], 4'd0, ad[i], 64'd0, md[i], ex[i], 1'b0, 0, $sformatf("load%0d", i));
            checks++;
            if (obs_lat !== c_lat + 1 || obs_ren !== c_lat || obs_wen !== 0) begin
                errors++;
                $display("FAIL load%0d_timing: lat=%0d ren=%0d wen=%0d, expected %0d %0d 0",
                         i, obs_lat, obs_ren, obs_wen, c_lat + 1, c_lat);
            end
            checks++;
            if (cap_raddr !== (ad[i] & ~64'h7)) begin
                errors++;
                $display("FAIL load%0d_raddr: got %h, expected %h", i, cap_raddr, ad[i] & ~64'h7);
            end
        end
    endtask

    task automatic test_stores();
        logic [3:0]  st [4];
        logic [63:0] ad [4];
        logic [63:0] wd [4];
        logic [63:0] ea [4];
        logic [7:0]  em [4];
        logic [63:0] ed [4];
        st[0] = c_sh; ad[0] = 64'h8000_0006; wd[0] = 64'h1234;
        ea[0] = 64'h8000_0000; em[0] = 8'hC0; ed[0] = 64'h1234_0000_0000_0000;
        st[1] = c_sb; ad[1] = 64'h8000_0005; wd[1] = 64'hAB;
        ea[1] = 64'h8000_0000; em[1] = 8'h20; ed[1] = 64'h0000_AB00_0000_0000;
        st[2] = c_sw; ad[2] = 64'h8000_000C; wd[2] = 64'hDEAD_BEEF;
        ea[2] = 64'h8000_0008; em[2] = 8'hF0; ed[2] = 64'hDEAD_BEEF_0000_0000;
        st[3] = c_sd; ad[3] = 64'h8000_0010; wd[3] = 64'h0123_4567_89AB_CDEF;
        ea[3] = 64'h8000_0010; em[3] = 8'hFF; ed[3] = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 4; i++) begin
            run_txn(7'd0, st[i], ad[i], wd[i], c_pat, 64'd0, 1'b0, 0, $sformatf("store%0d", i));
            checks++;
            if (obs_wen !== 1 || obs_ren !== 0 || obs_lat !== c_lat + 1) begin
                errors++;
                $display("FAIL store%0d_timing: wen=%0d ren=%0d lat=%0d, expected 1 0 %0d",
                         i, obs_wen, obs_ren, obs_lat, c_lat + 1);
            end
            checks++;
            if (cap_waddr !== ea[i] || cap_wmask !== em[i] || cap_wdata !== ed[i]) begin
                errors++;
                $display("FAIL store%0d_lanes: waddr=%h wmask=%h wdata=%h, expected %h %h %h",
                         i, cap_waddr, cap_wmask, cap_wdata, ea[i], em[i], ed[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [6:0]  ld [9];
        logic [3:0]  st [9];
        logic [63:0] ad [9];
        ld[0] = c_lw;       st[0] = 4'd0;    ad[0] = 64'h8000_0002;
        ld[1] = c_ld;       st[1] = 4'd0;    ad[1] = 64'h8000_0004;
        ld[2] = c_lhu;      st[2] = 4'd0;    ad[2] = 64'h8000_0001;
        ld[3] = 7'd0;       st[3] = c_sw;    ad[3] = 64'h8000_0006;
        ld[4] = 7'd0;       st[4] = c_sd;    ad[4] = 64'h8000_0004;
        ld[5] = 7'd0;       st[5] = 4'd0;    ad[5] = 64'h8000_0000;
        ld[6] = c_lb;       st[6] = c_sb;    ad[6] = 64'h8000_0000;
        ld[7] = 7'b0000011; st[7] = 4'd0;    ad[7] = 64'h8000_0000;
        ld[8] = 7'd0;       st[8] = 4'b0101; ad[8] = 64'h8000_0000;
        for (int i = 0; i < 9; i++) begin
            run_txn(ld[i], st[i], ad[i], 64'hFFFF, c_pat, 64'd0, 1'b1, 0, $sformatf("err%0d", i));
            checks++;
            if (obs_lat !== 1 || obs_ren !== 0 || obs_wen !== 0) begin
                errors++;
                $display("FAIL err%0d_no_access: lat=%0d ren=%0d wen=%0d, expected 1 0 0",
                         i, obs_lat, obs_ren, obs_wen);
            end
        end
    endtask

    task automatic test_backpressure();
        run_txn(c_lh, 4'd0, 64'h8000_0002, 64'd0, 64'h0000_0000_7FFF_0000,
                64'h0000_0000_0000_7FFF, 1'b0, 3, "backpressure");
        checks++;
        if (obs_ready_in_resp !== 1'b0 || obs_hold_ok !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: req_ready=%b stable=%b, expected 0 1", obs_ready_in_resp, obs_hold_ok);
        end
        checks++;
        if (obs_ready_after !== 1'b1 || obs_valid_after !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: req_ready=%b resp_valid=%b, expected 1 0", obs_ready_after, obs_valid_after);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        req_ld_type = c_lb; req_st_type = 4'd0; req_addr = 64'h8000_0003;
        mem_rdata = 64'h0000_0000_8000_0000; resp_ready = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (resp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_resp: resp_valid=%b req_ready=%b, expected 1 0", resp_valid, req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || mem_ren !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_accept_on_handshake: req_ready=%b mem_ren=%b resp_valid=%b, expected 1 0 0",
                     req_ready, mem_ren, resp_valid);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (mem_ren !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_second_accept: mem_ren=%b req_ready=%b, expected 1 0", mem_ren, req_ready);
        end
        n = 0;
        while (resp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_access();
        int   n, ren;
        logic bad;
        // Full access at MEM_LAT=4 first so the result register is non-zero
        req_ld_type = c_ld; req_st_type = 4'd0; req_addr = 64'h8000_0010;
        mem_rdata = c_pat; resp_ready = 1'b1; req_valid4 = 1'b1;
        @(posedge clk); #1;
        req_valid4 = 1'b0;
        n = 1; ren = 0;
        while (resp_valid4 !== 1'b1 && n < 40) begin
            if (mem_ren4 === 1'b1) ren++;
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n !== c_lat4 + 1 || ren !== c_lat4 || resp_rdata4 !== c_pat) begin
            errors++;
            $display("FAIL lat4_load: lat=%0d ren=%0d rdata=%h, expected %0d %0d %h",
                     n, ren, resp_rdata4, c_lat4 + 1, c_lat4, c_pat);
        end
        @(posedge clk); #1;
        // Second access, interrupted by reset in its second ACCESS cycle
        req_valid4 = 1'b1;
        @(posedge clk); #1;
        req_valid4 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_ren4 !== 1'b1 || req_ready4 !== 1'b0) begin
            errors++; $display("FAIL mid_access_setup: mem_ren=%b req_ready=%b, expected 1 0", mem_ren4, req_ready4);
        end
        #2 rst_n4 = 1'b0;
        #1;
        checks++;
        if (req_ready4 !== 1'b1 || resp_valid4 !== 1'b0 || resp_err4 !== 1'b0 || resp_rdata4 !== 64'd0 ||
            mem_ren4 !== 1'b0 || mem_wen4 !== 1'b0 || mem_wmask4 !== 8'h00 ||
            mem_raddr4 !== 64'd0 || mem_waddr4 !== 64'd0 || mem_wdata4 !== 64'd0) begin
            errors++;
            $display("FAIL async_reset: ready=%b valid=%b err=%b rdata=%h ren=%b wen=%b wmask=%h raddr=%h, expected reset values",
                     req_ready4, resp_valid4, resp_err4, resp_rdata4, mem_ren4, mem_wen4, mem_wmask4, mem_raddr4);
        end
        #1 rst_n4 = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (resp_valid4 !== 1'b0 || mem_ren4 !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL reset_abandon: resp_valid or mem_ren seen after reset, got %b expected 0", bad);
        end
        // Accept on the very first rising edge after reset release
        rst_n4 = 1'b0;
        #2;
        rst_n4 = 1'b1;
        req_valid4 = 1'b1;
        @(posedge clk); #1;
        req_valid4 = 1'b0;
        checks++;
        if (mem_ren4 !== 1'b1) begin
            errors++; $display("FAIL first_edge_accept: mem_ren=%b, expected 1", mem_ren4);
        end
        n = 0;
        while (resp_valid4 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; rst_n4 = 1'b0;
        req_valid = 1'b0; req_valid4 = 1'b0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0;
        req_ld_type = '0; req_st_type = '0; resp_ready = 1'b1;

        test_reset();
        test_lb_sign();
        test_lwu();
        test_loads();
        test_stores();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_access();

        checks++;
        if (sb_q.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have parameter MEM_LAT, default 1, meaning the number of cycles mem_ren is held and the cycle count before mem_rdata is sampled (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock, rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset, asynchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 1, the EXU request valid.
REQ-005 The block SHALL have port req_ready, output, 1, the request accept.
REQ-006 The block SHALL have port req_addr, input, 64, the byte address.
REQ-007 The block SHALL have port req_wdata, input, 64, the store data, right-aligned.
REQ-008 The block SHALL have port req_ld_type, input, 7, one-hot {LWU,LHU,LBU,LD,LW,LH,LB} (bit6..bit0).
REQ-009 The block SHALL have port req_st_type, input, 4, one-hot {SD,SW,SH,SB} (bit3..bit0).
REQ-010 The block SHALL have port resp_valid, output, 1, the result valid.
REQ-011 The block SHALL have port resp_ready, input, 1, the WBU accept.
REQ-012 The block SHALL have port resp_rdata, output, 64, the extended load result (0 for stores).
REQ-013 The block SHALL have port resp_err, output, 1, flagging a misaligned or illegal request.
REQ-014 The block SHALL have port mem_raddr, output, 64, the 8-byte-aligned read address to MEM.
REQ-015 The block SHALL have port mem_rdata, input, 64, the read data from MEM.
REQ-016 The block SHALL have port mem_ren, output, 1, the MEM Read_en.
REQ-017 The block SHALL have port mem_waddr, output, 64, the 8-byte-aligned write address to MEM.
REQ-018 The block SHALL have port mem_wdata, output, 64, the lane-shifted store data.
REQ-019 The block SHALL have port mem_wmask, output, 8, the byte-lane mask.
REQ-020 The block SHALL have port mem_wen, output, 1, the MEM Write_en.

Function
REQ-021 The FSM SHALL have the states IDLE, ACCESS and RESP, and req_ready SHALL be 1 only in IDLE.
REQ-022 In IDLE, req_valid&&req_ready SHALL latch addr/wdata/ld_type/st_type into internal registers.
REQ-023 From IDLE, the next state SHALL be RESP with resp_err=1 if the request is illegal (ld_type and st_type both zero, both nonzero, or either not one-hot); otherwise it SHALL be RESP with resp_err=1 if misaligned (H: addr[0]!=0; W: addr[1:0]!=0; D: addr[2:0]!=0); otherwise it SHALL be ACCESS.
REQ-024 An errored request SHALL never assert mem_ren or mem_wen, and its resp_rdata SHALL be 0.
REQ-025 In ACCESS for a load, mem_ren SHALL be 1 for exactly MEM_LAT cycles, with mem_raddr={addr[63:3],3'b0}.
REQ-026 mem_rdata SHALL be captured on the final ACCESS cycle.
REQ-027 In ACCESS for a store, mem_wen SHALL be 1 only on the first ACCESS cycle, and ACCESS SHALL last MEM_LAT cycles.
REQ-028 A store SHALL drive mem_waddr={addr[63:3],3'b0}, mem_wmask=(B:0x01, H:0x03, W:0x0F, D:0xFF)<<addr[2:0], and mem_wdata=req_wdata<<(8*addr[2:0]).
REQ-029 Outside the enabled cycles, mem_ren, mem_wen and mem_wmask SHALL be 0.
REQ-030 Load extraction SHALL be shifted=captured>>(8*addr[2:0]), then the low 8/16/32/64 bits of shifted, sign-extended for LB/LH/LW and zero-extended for LBU/LHU/LWU.
REQ-031 resp_rdata SHALL be registered and stable throughout RESP.
REQ-032 In RESP, resp_valid SHALL be 1 and SHALL hold until resp_ready=1.
REQ-033 On the cycle of that handshake the FSM SHALL move to IDLE, and a new request SHALL NOT be accepted on that same cycle.
REQ-034 Latency from accept edge to resp_valid SHALL be MEM_LAT+1 cycles for a legal access and 1 cycle for an errored one.
REQ-035 The counter SHALL be 4 bits, SHALL reset to 0 on entry to ACCESS, and SHALL NOT wrap within a transaction.

Reset
REQ-036 Asserting rst_n=0 SHALL immediately force state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_ren=0, mem_wen=0, mem_wmask=0, all mem addr/data outputs to 0, and the counter to 0.
REQ-037 Reset mid-ACCESS SHALL abandon the transaction and produce no response.
REQ-038 After release, the first accept SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-039 The bench SHALL apply LB at 0x80000003 with mem_rdata=0x00000000_80000000 and check resp_rdata=0xFFFFFFFFFFFFFF80, resp_err=0, and resp_valid at cycle 2 (MEM_LAT=1).
REQ-040 The bench SHALL apply LWU at 0x80000004 with mem_rdata=0x89ABCDEF_00000000 and check resp_rdata=0x0000000089ABCDEF.
REQ-041 The bench SHALL apply SH at 0x80000006 with req_wdata=0x1234 and check mem_waddr=0x80000000, mem_wmask=0xC0, mem_wdata=0x1234000000000000, and mem_wen high for exactly 1 cycle.
REQ-042 The bench SHALL apply LW at 0x80000002 and check resp_err=1 one cycle after accept, mem_ren never asserted, and resp_rdata=0.
REQ-043 The bench SHALL hold resp_ready=0 for 3 cycles in RESP and check that resp_valid and resp_rdata stay stable and req_ready=0, then that req_ready=1 on the cycle after the handshake.
REQ-044 The bench SHALL pulse rst_n=0 in the middle of ACCESS with MEM_LAT=4 and check that all outputs reach reset values with no clock edge and that no resp_valid follows.
